// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative shift-add multiplier.
// Optional signed-overflow output vout is built only when ALU_MC_OVF_EN is defined.
module alu_mc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zout,
`ifdef ALU_MC_OVF_EN
   output logic             vout,
`endif
   output logic [1:0]       dbg_state
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             zout_q, zout_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mult_q, mult_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic             mulh_q, mulh_d;
   logic [SHW:0]     cnt_q, cnt_d;
`ifdef ALU_MC_OVF_EN
   logic             vout_q, vout_d;
   logic             sc_vout;
`endif

   logic [SHW-1:0]     sh;
   logic [2*WIDTH-1:0] sll_ext;
   logic [WIDTH:0]     srl_ext, sra_ext;
   logic [WIDTH-1:0]   rol_res, add_b;
   logic               add_c;
   logic [WIDTH:0]     arith;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_cout;

   // Shifts keep one extra bit beyond the result so the last bit shifted out falls out for free.
   always_comb begin
      sh      = b[SHW-1:0];
      sll_ext = {{WIDTH{1'b0}}, a} << sh;
      srl_ext = {a, 1'b0} >> sh;
      sra_ext = srl_ext | ({(WIDTH+1){a[MSB]}} & ~({(WIDTH+1){1'b1}} >> sh));
      rol_res = sll_ext[WIDTH-1:0] | sll_ext[2*WIDTH-1:WIDTH];
      add_b   = op[1] ? ~b : b;
      add_c   = op[0] ? cin : op[1];
      arith   = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
      sc_res  = a;
      sc_cout = 1'b0;
      case (op)
         4'd0:        sc_res = a & b;
         4'd1:        sc_res = a | b;
         4'd2:        sc_res = a ^ b;
         4'd3:        sc_res = ~a;
         4'd4, 4'd5,
         4'd6, 4'd7: begin
            sc_res  = arith[WIDTH-1:0];
            sc_cout = arith[WIDTH];
         end
         4'd8: begin
            sc_res  = sll_ext[WIDTH-1:0];
            sc_cout = sll_ext[WIDTH];
         end
         4'd9: begin
            sc_res  = srl_ext[WIDTH:1];
            sc_cout = srl_ext[0];
         end
         4'd10: begin
            sc_res  = sra_ext[WIDTH:1];
            sc_cout = sra_ext[0];
         end
         4'd11: begin
            sc_res  = rol_res;
            sc_cout = (sh != '0) & rol_res[0];
         end
         default: ;
      endcase
   end

`ifdef ALU_MC_OVF_EN
   always_comb begin
      sc_vout = 1'b0;
      if (op == 4'd4 || op == 4'd5)
         sc_vout = (a[MSB] == b[MSB]) && (arith[MSB] != a[MSB]);
      else if (op == 4'd6 || op == 4'd7)
         sc_vout = (a[MSB] != b[MSB]) && (arith[MSB] != a[MSB]);
   end
`endif

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo, mul_res;
   logic             is_mul, accept;

   // One shift-add step: {acc, mult} holds the partial product, shifted right each cycle.
   always_comb begin
      mul_sum = {1'b0, acc_q} + (mult_q[0] ? {1'b0, mcand_q} : '0);
      mul_hi  = mul_sum[WIDTH:1];
      mul_lo  = {mul_sum[0], mult_q[WIDTH-1:1]};
      mul_res = mulh_q ? mul_hi : mul_lo;
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      cout_d   = cout_q;
      zout_d   = zout_q;
      acc_d    = acc_q;
      mult_d   = mult_q;
      mcand_d  = mcand_q;
      mulh_d   = mulh_q;
      cnt_d    = cnt_q;
`ifdef ALU_MC_OVF_EN
      vout_d   = vout_q;
`endif
      in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      accept   = in_valid && in_ready;
      is_mul   = (op == 4'd12) || (op == 4'd13);

      case (state_q)
         BUSY: begin
            acc_d  = mul_hi;
            mult_d = mul_lo;
            cnt_d  = cnt_q - (SHW+1)'(1);
            if (cnt_q == (SHW+1)'(1)) begin
               state_d  = DONE;
               result_d = mul_res;
               cout_d   = ~mulh_q & (mul_hi != '0);
               zout_d   = (mul_res == '0);
`ifdef ALU_MC_OVF_EN
               vout_d   = 1'b0;
`endif
            end
         end
         DONE:    if (out_ready) state_d = IDLE;
         default: ;
      endcase

      // A new request may land in IDLE or in the same cycle DONE hands off its response.
      if (accept) begin
         if (is_mul) begin
            state_d = BUSY;
            acc_d   = '0;
            mult_d  = b;
            mcand_d = a;
            mulh_d  = op[0];
            cnt_d   = (SHW+1)'(WIDTH);
         end else begin
            state_d  = DONE;
            result_d = sc_res;
            cout_d   = sc_cout;
            zout_d   = (sc_res == '0);
`ifdef ALU_MC_OVF_EN
            vout_d   = sc_vout;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         cout_q   <= 1'b0;
         zout_q   <= 1'b0;
         acc_q    <= '0;
         mult_q   <= '0;
         mcand_q  <= '0;
         mulh_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef ALU_MC_OVF_EN
         vout_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         zout_q   <= zout_d;
         acc_q    <= acc_d;
         mult_q   <= mult_d;
         mcand_q  <= mcand_d;
         mulh_q   <= mulh_d;
         cnt_q    <= cnt_d;
`ifdef ALU_MC_OVF_EN
         vout_q   <= vout_d;
`endif
      end
   end

   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign cout      = cout_q;
   assign zout      = zout_q;
   assign dbg_state = state_q;
`ifdef ALU_MC_OVF_EN
   assign vout      = vout_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=8: vector table, directed multi-cycle sequences, random stream.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module tb_alu_mc;
  localparam int W  = 8;
  localparam int EW = W + 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout;
  logic         zout;
  logic [1:0]   dbg_state;
`ifdef ALU_MC_OVF_EN
  logic         vout;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic rand_bp = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zout(zout),
`ifdef ALU_MC_OVF_EN
    .vout(vout),
`endif
    .dbg_state(dbg_state)
  );

  // clock / cycle counter / random backpressure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rand_bp) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: {result, cout, zout, vout}
  function automatic logic [EW-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic c);
    int unsigned t;
    logic [W-1:0] r;
    logic co, v;
    int s;
    r = '0; co = 1'b0; v = 1'b0; s = int'(y[2:0]); t = 0;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x ^ y;
      4'd3: r = ~x;
      4'd4, 4'd5: begin
        t = 32'(x) + 32'(y) + ((o == 4'd5) ? 32'(c) : 32'd0);
        r = t[7:0]; co = t[8];
        v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      4'd6, 4'd7: begin
        t = 32'd256 + 32'(x) - 32'(y) - ((o == 4'd7) ? 32'(!c) : 32'd0);
        r = t[7:0]; co = t[8];
        v = (x[7] != y[7]) && (r[7] != x[7]);
      end
      4'd8, 4'd9, 4'd10, 4'd11: begin
        r = x;
        for (int i = 0; i < s; i++) begin
          case (o)
            4'd8:    begin co = r[7]; r = {r[6:0], 1'b0}; end
            4'd9:    begin co = r[0]; r = {1'b0, r[7:1]}; end
            4'd10:   begin co = r[0]; r = {r[7], r[7:1]}; end
            default: begin co = r[7]; r = {r[6:0], r[7]}; end
          endcase
        end
      end
      4'd12: begin t = 32'(x) * 32'(y); r = t[7:0]; co = (t[15:8] != 8'h00); end
      4'd13: begin t = 32'(x) * 32'(y); r = t[15:8]; end
      default: r = x;
    endcase
    return {r, co, (r == '0), v};
  endfunction

  // scoreboard: pop and compare on every response handshake
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp_unexpected actual=%0h expected=none", result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_result", 32'(result), 32'(mon_e[EW-1:3]));
        chk("resp_cout", 32'(cout), 32'(mon_e[2]));
        chk("resp_zout", 32'(zout), 32'(mon_e[1]));
`ifdef ALU_MC_OVF_EN
        chk("resp_vout", 32'(vout), 32'(mon_e[0]));
`endif
      end
    end
  end

  // driver: called at posedge+2, leaves in_valid high, returns at posedge+2 after accept
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c, input logic [EW-1:0] e);
    int n;
    op = o; a = x; b = y; cin = c; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=in_ready_0 expected=in_ready_1");
      in_valid = 1'b0;
      @(posedge clk); #2;
      return;
    end
    exp_q.push_back(e);
    acc_cyc = cyc;
    @(posedge clk); #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #2;
  endtask

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } vec_t;

  vec_t vecs[25];
  int   acc_t[4];

  initial begin
    vecs = '{
      '{4'd4,  8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0},
      '{4'd10, 8'h81, 8'h01, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0},
      '{4'd6,  8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0},
      '{4'd7,  8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0},
      '{4'd12, 8'h12, 8'h34, 1'b0, 8'hA8, 1'b1, 1'b0, 1'b0},
      '{4'd13, 8'h12, 8'h34, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0},
      '{4'd0,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0},
      '{4'd1,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0},
      '{4'd2,  8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd3,  8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0},
      '{4'd5,  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0},
      '{4'd8,  8'h81, 8'h01, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0},
      '{4'd9,  8'h81, 8'h01, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0},
      '{4'd9,  8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0},
      '{4'd11, 8'h81, 8'h01, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0},
      '{4'd11, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0},
      '{4'd14, 8'h5A, 8'h33, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0},
      '{4'd15, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd4,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1},
      '{4'd6,  8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1},
      '{4'd8,  8'h03, 8'h07, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0},
      '{4'd13, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0},
      '{4'd12, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0},
      '{4'd12, 8'h00, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0},
      '{4'd10, 8'h80, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0}
    };

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_zout", 32'(zout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_MC_OVF_EN
    chk("rst_vout", 32'(vout), 32'd0);
`endif
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;

    // single-cycle latency
    send(4'd4, 8'hF0, 8'h20, 1'b0, {8'h10, 1'b1, 1'b0, 1'b0});
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2;

    // vector table, back-to-back
    for (int i = 0; i < 25; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
           {vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v});
    in_valid = 1'b0;
    drain();

    // multiply latency; inputs scrambled while busy
    for (int k = 0; k < 2; k++) begin
      send((k == 0) ? 4'd12 : 4'd13, 8'h12, 8'h34, 1'b0,
           (k == 0) ? {8'hA8, 1'b1, 1'b0, 1'b0} : {8'h03, 1'b0, 1'b0, 1'b0});
      in_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        op = 4'($urandom_range(0, 15));
        chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
        chk("mul_busy_out_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      chk("mul_lat_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #2;
    end

    // backpressure: hold 5 cycles with a competing request pending
    out_ready = 1'b0;
    send(4'd4, 8'h11, 8'h22, 1'b0, {8'h33, 1'b0, 1'b0, 1'b0});
    op = 4'd2; a = 8'h0F; b = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(result), 32'h33);
      chk("bp_queue", 32'(exp_q.size()), 32'd1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(4'd2, 8'h0F, 8'hF0, 1'b0, {8'hFF, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b0;
    drain();

    // streaming: four ADDs, one per cycle
    for (int i = 0; i < 4; i++) begin
      send(4'd4, 8'(i * 16), 8'h01, 1'b0, model(4'd4, 8'(i * 16), 8'h01, 1'b0));
      acc_t[i] = acc_cyc;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      chk("stream_no_bubble", 32'(acc_t[i] - acc_t[i-1]), 32'd1);
    drain();

    // random stream with random response backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] o;
      logic [W-1:0] x, y;
      logic c;
      o = 4'($urandom_range(0, 15));
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      send(o, x, y, c, model(o, x, y, c));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #2;
      end
    end
    in_valid = 1'b0;
    rand_bp = 1'b0;
    @(posedge clk); #3;
    out_ready = 1'b1;
    drain();

    // reset during a multiply
    send(4'd4, 8'h40, 8'h01, 1'b0, {8'h41, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b0;
    drain();
    send(4'd12, 8'h12, 8'h34, 1'b0, {8'hA8, 1'b1, 1'b0, 1'b0});
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    send(4'd4, 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b0, 1'b1});
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
